qspi_top: RTL and testbench

- Memory-mapped QSPI flash master with a simplified AHB-style slave register port.
- Host writes configuration and command registers, then sets START.
- Block runs one flash transaction (command, address, dummy, data) in single-line or quad mode on cs_n/sclk/io0-3.
- Sits between the system bus and an external SPI/QSPI flash device.

---
 rtl/qspi_top.sv | 252 +++++++++++++++++++++++++
 tb/tb_qspi_top.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qspi_top - memory-mapped QSPI flash master with an AHB-style register port.
// Optional macro QSPI_HTRANS_CHECK_EN: qualify bus accesses with h_trans[1].
// Rev 1.0
// ---------------------------------------------------------------------------
module qspi_top #(
  parameter logic [7:0] CLK_DIV_RST = 8'h01,
  parameter int         ADDR_BYTES  = 3
) (
  input  logic        h_clk,
  input  logic        h_rst,
  input  logic [31:0] h_wdata,
  input  logic [31:0] h_addr,
  input  logic [2:0]  h_burst,
  input  logic [1:0]  h_trans,
  input  logic        h_write,
  input  logic        h_sel,
  output logic        h_ready,
  output logic [1:0]  h_resp,
  output logic [31:0] h_rdata,
  output logic        cs_n,
  output logic        sclk,
  inout  wire         io0,
  inout  wire         io1,
  inout  wire         io2,
  inout  wire         io3
);

  localparam int ABITS = 8 * ADDR_BYTES;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        sclk_q, sclk_d, cs_n_q, cs_n_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [5:0]  cyc_q, cyc_d;
  logic [31:0] sr_q, sr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d, quad_q, quad_d, dir_q, dir_d;
  logic [7:0]  clk_div_q, clk_div_d, cmd_q, cmd_d;
  logic [2:0]  len_q, len_d;
  logic [3:0]  dummy_q, dummy_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;

  logic        bus_ok, wr, rd, busy, to_data;
  logic [7:0]  div_last;
  logic [2:0]  nbytes;
  logic [5:0]  data_cyc, addr_cyc;
  logic [3:0]  io_in, io_oe, io_out;
  logic        unused_bits;

`ifdef QSPI_HTRANS_CHECK_EN
  assign bus_ok = h_sel & h_trans[1];
`else
  assign bus_ok = h_sel;
`endif
  assign unused_bits = ^{h_burst, h_trans, h_addr[31:8]};

  assign wr       = bus_ok & h_write;
  assign rd       = bus_ok & ~h_write;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign div_last = (clk_div_q == 8'd0) ? 8'd0 : clk_div_q - 8'd1;
  assign nbytes   = (len_q[1:0] == 2'd0) ? 3'd4 : {1'b0, len_q[1:0]};
  assign data_cyc = quad_q ? {2'b0, nbytes, 1'b0} : {nbytes, 3'b0};
  assign addr_cyc = quad_q ? 6'(2 * ADDR_BYTES) : 6'(ABITS);
  assign io_in    = {io3, io2, io1, io0};

  assign h_ready = 1'b1;
  assign h_resp  = 2'b00;
  assign cs_n    = cs_n_q;
  assign sclk    = sclk_q;

  assign io0 = io_oe[0] ? io_out[0] : 1'bz;
  assign io1 = io_oe[1] ? io_out[1] : 1'bz;
  assign io2 = io_oe[2] ? io_out[2] : 1'bz;
  assign io3 = io_oe[3] ? io_out[3] : 1'bz;

  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    div_cnt_d = div_cnt_q;
    cyc_d     = cyc_q;
    sr_d      = sr_q;
    rdata_d   = rdata_q;
    done_d    = done_q;
    quad_d    = quad_q;
    dir_d     = dir_q;
    clk_div_d = clk_div_q;
    len_d     = len_q;
    dummy_d   = dummy_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    to_data   = 1'b0;

    if (wr && h_addr[7:0] == 8'h1C && h_wdata[1]) done_d = 1'b0;
    if (wr && !busy) begin
      case (h_addr[7:0])
        8'h00: begin quad_d = h_wdata[1]; dir_d = h_wdata[2]; end
        8'h04: clk_div_d = h_wdata[7:0];
        8'h08: begin len_d = h_wdata[2:0]; dummy_d = h_wdata[11:8]; end
        8'h0C: cmd_d = h_wdata[7:0];
        8'h10: addr_d = h_wdata;
        8'h14: wdata_d = h_wdata;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (wr && h_addr[7:0] == 8'h00 && h_wdata[0]) begin
          state_d   = S_CMD;
          sr_d      = {cmd_q, 24'h0};
          cyc_d     = 6'd8;
          // first sclk rise lands one h_clk after cs_n falls
          div_cnt_d = div_last;
          sclk_d    = 1'b0;
          if (h_wdata[2]) rdata_d = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (div_cnt_q >= div_last) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            if (state_q == S_DATA && dir_q)
              rdata_d = quad_q ? {rdata_q[27:0], io_in} : {rdata_q[30:0], io_in[1]};
          end else if (cyc_q != 6'd1) begin
            cyc_d = cyc_q - 6'd1;
            sr_d  = (quad_q && state_q != S_CMD) ? {sr_q[27:0], 4'h0} : {sr_q[30:0], 1'b0};
          end else begin
            case (state_q)
              S_CMD: begin
                state_d = S_ADDR;
                sr_d    = addr_q << (32 - ABITS);
                cyc_d   = addr_cyc;
              end
              S_ADDR: begin
                if (dummy_q != 4'd0) begin
                  state_d = S_DUMMY;
                  cyc_d   = {2'b0, dummy_q};
                end else begin
                  to_data = 1'b1;
                end
              end
              S_DUMMY: to_data = 1'b1;
              default: begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            endcase
            if (to_data) begin
              state_d = S_DATA;
              sr_d    = wdata_q;
              cyc_d   = data_cyc;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
    endcase

    cs_n_d = (state_d == S_IDLE) || (state_d == S_DONE);
  end

  // Single mode holds WP#/HOLD# high; quad DUMMY and read DATA float all lines.
  always_comb begin
    io_oe  = 4'h0;
    io_out = 4'h0;
    if (busy) begin
      if (!quad_q || state_q == S_CMD) begin
        io_oe[3:2]  = 2'b11;
        io_out[3:2] = 2'b11;
      end
      if (state_q == S_CMD ||
          (!quad_q && (state_q == S_ADDR || (state_q == S_DATA && !dir_q)))) begin
        io_oe[0]  = 1'b1;
        io_out[0] = sr_q[31];
      end else if (quad_q && (state_q == S_ADDR || (state_q == S_DATA && !dir_q))) begin
        io_oe  = 4'hF;
        io_out = sr_q[31:28];
      end
    end
  end

  always_comb begin
    h_rdata = 32'h0;
    if (rd) begin
      case (h_addr[7:0])
        8'h00:   h_rdata = {29'h0, dir_q, quad_q, 1'b0};
        8'h04:   h_rdata = {24'h0, clk_div_q};
        8'h08:   h_rdata = {20'h0, dummy_q, 5'h0, len_q};
        8'h0C:   h_rdata = {24'h0, cmd_q};
        8'h10:   h_rdata = addr_q;
        8'h14:   h_rdata = wdata_q;
        8'h18:   h_rdata = rdata_q;
        8'h1C:   h_rdata = {30'h0, done_q, busy};
        default: h_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      state_q   <= S_IDLE;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      div_cnt_q <= '0;
      cyc_q     <= '0;
      sr_q      <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      quad_q    <= 1'b0;
      dir_q     <= 1'b0;
      clk_div_q <= CLK_DIV_RST;
      len_q     <= '0;
      dummy_q   <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      div_cnt_q <= div_cnt_d;
      cyc_q     <= cyc_d;
      sr_q      <= sr_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      quad_q    <= quad_d;
      dir_q     <= dir_d;
      clk_div_q <= clk_div_d;
      len_q     <= len_d;
      dummy_q   <= dummy_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qspi_top.sv
`default_nettype none
// tb_qspi_top: directed bench for qspi_top with an io-line scoreboard and a
// small quad-read flash model.
module tb_qspi_top;

  logic        h_clk = 1'b0;
  logic        h_rst = 1'b1;
  logic [31:0] h_wdata = '0;
  logic [31:0] h_addr = '0;
  logic [2:0]  h_burst = '0;
  logic [1:0]  h_trans = 2'b10;
  logic        h_write = 1'b0;
  logic        h_sel = 1'b0;
  logic        h_ready;
  logic [1:0]  h_resp;
  logic [31:0] h_rdata;
  logic        cs_n, sclk;
  wire         io0, io1, io2, io3;

  pulldown (io0);
  pulldown (io1);
  pullup   (io2);
  pullup   (io3);

  qspi_top dut (
    .h_clk(h_clk), .h_rst(h_rst), .h_wdata(h_wdata), .h_addr(h_addr),
    .h_burst(h_burst), .h_trans(h_trans), .h_write(h_write), .h_sel(h_sel),
    .h_ready(h_ready), .h_resp(h_resp), .h_rdata(h_rdata),
    .cs_n(cs_n), .sclk(sclk), .io0(io0), .io1(io1), .io2(io2), .io3(io3)
  );

  always #5 h_clk = ~h_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected io values at each sclk rise: only bits under mask are compared.
  typedef struct packed {
    logic [3:0] val;
    logic [3:0] mask;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] exp_rd[$];

  int  rise_cnt = 0;
  time t_prev = 0;
  time t_last = 0;
  always @(posedge sclk) begin
    exp_t e;
    t_prev = t_last;
    t_last = $time;
    rise_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("io_lines", {28'h0, {io3, io2, io1, io0} & e.mask}, {28'h0, e.val});
      chk("cs_n_active", 32'(cs_n), 32'h0);
    end
  end

  // Flash model: drives read data after 8+6+4 sclk cycles of a quad read.
  logic        flash_en = 1'b0;
  int          fall_cnt = 0;
  int          fall_base = 0;
  logic [31:0] flash_data = 32'hCAFEBABE;
  int          rel;
  logic        flash_on;
  logic [3:0]  flash_nib;
  always @(negedge sclk) fall_cnt++;
  always_comb begin
    rel       = fall_cnt - fall_base;
    flash_on  = flash_en && !cs_n && rel >= 18 && rel < 26;
    flash_nib = 4'(flash_data >> (4 * (25 - rel)));
  end
  assign io0 = flash_on ? flash_nib[0] : 1'bz;
  assign io1 = flash_on ? flash_nib[1] : 1'bz;
  assign io2 = flash_on ? flash_nib[2] : 1'bz;
  assign io3 = flash_on ? flash_nib[3] : 1'bz;

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge h_clk);
    h_sel = 1'b1; h_write = 1'b1; h_addr = {24'h0, a}; h_wdata = d;
    @(negedge h_clk);
    h_sel = 1'b0; h_write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge h_clk);
    h_sel = 1'b1; h_write = 1'b0; h_addr = {24'h0, a};
    #1 d = h_rdata;
    h_sel = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] st;
    st = 32'h1;
    for (int i = 0; i < budget; i++) begin
      bus_read(8'h1C, st);
      if (!st[0]) break;
    end
    chk("wait_idle_busy", {31'h0, st[0]}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          base;
    logic [39:0] sv;
    logic [23:0] qa;
    logic [7:0]  qc;

    repeat (3) @(negedge h_clk);
    #1;
    chk("rst_cs_n", 32'(cs_n), 32'h1);
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_io0_float", 32'(io0), 32'h0);
    chk("h_ready", 32'(h_ready), 32'h1);
    chk("h_resp", 32'(h_resp), 32'h0);
    h_rst = 1'b0;
    bus_read(8'h1C, rd); chk("rst_status", rd, 32'h0);
    bus_read(8'h04, rd); chk("rst_clk_div", rd, 32'h1);

    // register access
    bus_write(8'h00, 32'h2);
    bus_write(8'h04, 32'h1);
    bus_write(8'h0C, 32'h5A);
    bus_write(8'h10, 32'hDEADBEEF);
    bus_read(8'h00, rd); chk("reg_ctrl", rd, 32'h2);
    bus_read(8'h04, rd); chk("reg_clk_div", rd, 32'h1);
    bus_read(8'h0C, rd); chk("reg_cmd", rd, 32'h5A);
    bus_read(8'h10, rd); chk("reg_addr", rd, 32'hDEADBEEF);
    bus_read(8'h24, rd); chk("reg_unmapped", rd, 32'h0);
    chk("h_ready_2", 32'(h_ready), 32'h1);
    chk("h_resp_2", 32'(h_resp), 32'h0);

    // single-mode write: 0x02, 0x123456, 0xA5 on io0
    bus_write(8'h0C, 32'h02);
    bus_write(8'h10, 32'h00123456);
    bus_write(8'h08, 32'h1);
    bus_write(8'h14, 32'hA5000000);
    sv = {8'h02, 24'h123456, 8'hA5};
    for (int i = 39; i >= 0; i--) exp_q.push_back('{val: {2'b11, 1'b0, sv[i]}, mask: 4'b1101});
    base = rise_cnt;
    bus_write(8'h00, 32'h1);
    bus_write(8'h0C, 32'hFF);
    wait_idle(1000);
    chk("sw_sclk_cycles", 32'(rise_cnt - base), 32'd40);
    chk("sw_scoreboard_left", 32'(exp_q.size()), 32'h0);
    bus_read(8'h1C, rd); chk("sw_status_done", rd, 32'h2);
    bus_read(8'h0C, rd); chk("busy_cmd_write_ignored", rd, 32'h02);
    bus_write(8'h1C, 32'h2);
    bus_read(8'h1C, rd); chk("done_cleared", rd, 32'h0);

    // quad read with 4 dummy cycles
    bus_write(8'h0C, 32'hEB);
    bus_write(8'h10, 32'h77ABCDEF);
    bus_write(8'h08, 32'h0404);
    qc = 8'hEB;
    qa = 24'hABCDEF;
    for (int i = 7; i >= 0; i--) exp_q.push_back('{val: {3'b000, qc[i]}, mask: 4'b0001});
    for (int i = 5; i >= 0; i--) exp_q.push_back('{val: qa[4*i +: 4], mask: 4'b1111});
    exp_rd.push_back(32'hCAFEBABE);
    fall_base = fall_cnt;
    flash_en  = 1'b1;
    base      = rise_cnt;
    bus_write(8'h00, 32'h7);
    wait_idle(1000);
    flash_en = 1'b0;
    chk("qr_sclk_cycles", 32'(rise_cnt - base), 32'd26);
    chk("qr_scoreboard_left", 32'(exp_q.size()), 32'h0);
    bus_read(8'h18, rd); chk("qr_rdata", rd, exp_rd.pop_front());

    // sclk period for CLK_DIV=4 and CLK_DIV=0
    bus_write(8'h08, 32'h1);
    bus_write(8'h04, 32'h4);
    bus_write(8'h00, 32'h1);
    wait_idle(1000);
    chk("period_div4", 32'(t_last - t_prev), 32'd80);
    bus_write(8'h04, 32'h0);
    bus_write(8'h00, 32'h1);
    wait_idle(1000);
    chk("period_div0", 32'(t_last - t_prev), 32'd20);

    // reset during DATA
    bus_write(8'h04, 32'h1);
    base = rise_cnt;
    bus_write(8'h00, 32'h1);
    for (int i = 0; i < 500 && (rise_cnt - base) < 35; i++) @(negedge h_clk);
    chk("reach_data", 32'((rise_cnt - base) >= 35), 32'h1);
    @(negedge h_clk);
    h_rst = 1'b1;
    #1;
    chk("abort_cs_n", 32'(cs_n), 32'h1);
    chk("abort_sclk", 32'(sclk), 32'h0);
    chk("abort_io0_float", 32'(io0), 32'h0);
    @(negedge h_clk);
    h_rst = 1'b0;
    bus_read(8'h1C, rd); chk("abort_status", rd, 32'h0);
    bus_read(8'h0C, rd); chk("abort_cmd", rd, 32'h0);
    bus_read(8'h10, rd); chk("abort_addr", rd, 32'h0);
    bus_read(8'h04, rd); chk("abort_clk_div", rd, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
